// File: rtl/seg_pkg.sv
// Shared seven-segment constants and the character decode table used by
// every display driver in the design.
package seg_pkg;

  localparam logic [3:0] CHAR_BLANK = 4'hF;
  localparam logic [6:0] SEG_OFF    = 7'h7F;

  // One character-buffer slot: the code to decode plus its decimal point.
  typedef struct packed {
    logic [3:0] code;
    logic       dp;
  } seg_entry_t;

  localparam seg_entry_t ENTRY_BLANK = '{code: CHAR_BLANK, dp: 1'b0};

  // Active-low {a,b,c,d,e,f,g}; code F is the blank glyph.
  function automatic logic [6:0] seg_decode(input logic [3:0] code);
    logic [6:0] s;
    case (code)
      4'h0:    s = 7'b0000001;
      4'h1:    s = 7'b1001111;
      4'h2:    s = 7'b0010010;
      4'h3:    s = 7'b0000110;
      4'h4:    s = 7'b1001100;
      4'h5:    s = 7'b0100100;
      4'h6:    s = 7'b0100000;
      4'h7:    s = 7'b0001111;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0000100;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b1100000;
      4'hC:    s = 7'b0110001;
      4'hD:    s = 7'b1000010;
      4'hE:    s = 7'b0110000;
      default: s = SEG_OFF;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg_decoder.sv
// Combinational character-code to active-low segment decoder.
module seg_decoder
  import seg_pkg::*;
(
  input  logic [3:0] code_i,
  output logic [6:0] seg_o
);

  assign seg_o = seg_decode(code_i);

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed common-anode seven-segment scanner with an all-off guard window
// at the start of each digit slot so segment changes never ghost onto a lit digit.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int DWELL      = 4,
  parameter int GUARD      = 1,
  parameter int IDX_W      = $clog2(NUM_DIGITS)
) (
  input  logic                  state_clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [3:0]            wr_char,
  input  logic                  wr_dp,
  input  logic                  en,
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [IDX_W-1:0]      digit_idx
);

  localparam int                    PH_W     = $clog2(DWELL);
  localparam logic [PH_W-1:0]       PH_LAST  = PH_W'(DWELL - 1);
  localparam logic [PH_W-1:0]       PH_GUARD = PH_W'(GUARD);
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF   = {NUM_DIGITS{1'b1}};
  localparam logic [NUM_DIGITS-1:0] AN_ONE   = NUM_DIGITS'(1);

  seg_entry_t            buf_q [NUM_DIGITS];
  logic [PH_W-1:0]       phase_q, phase_d;
  logic [IDX_W-1:0]      digit_q, digit_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  seg_entry_t            snap_entry;
  logic [6:0]            snap_seg;
  logic                  wr_ok;

  assign wr_ok = wr_en && (int'(wr_idx) < NUM_DIGITS);

  // Snapshot reads the buffer slot of the digit about to own the slot.
  assign snap_entry = buf_q[digit_d];

  seg_decoder u_dec (
    .code_i (snap_entry.code),
    .seg_o  (snap_seg)
  );

  always_comb begin
    phase_d = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
    digit_d = digit_q;
    if (phase_q == PH_LAST) begin
      digit_d = (digit_q == '0) ? IDX_LAST : digit_q - 1'b1;
    end

    an_d  = an_q;
    seg_d = seg_q;
    dp_d  = dp_q;
    if (phase_d == '0) begin
      // Segments only change here, with every anode forced off.
      an_d  = AN_OFF;
      seg_d = snap_seg;
      dp_d  = ~snap_entry.dp;
    end else if (phase_d == PH_GUARD) begin
      an_d = en ? ~(AN_ONE << digit_q) : AN_OFF;
    end else if (!en) begin
      an_d = AN_OFF;
    end
  end

  always_ff @(posedge state_clk or posedge reset) begin
    if (reset) begin
      phase_q <= PH_LAST;
      digit_q <= '0;
      an_q    <= AN_OFF;
      seg_q   <= SEG_OFF;
      dp_q    <= 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        buf_q[i] <= ENTRY_BLANK;
      end
    end else begin
      phase_q <= phase_d;
      digit_q <= digit_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      if (wr_ok) begin
        buf_q[wr_idx] <= '{code: wr_char, dp: wr_dp};
      end
    end
  end

  assign an        = an_q;
  assign seg       = seg_q;
  assign dp        = dp_q;
  assign digit_idx = digit_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: a 4/4/1 and a 6/8/2 instance share stimulus and
// are compared every cycle against a slot/phase arithmetic model.
module tb_seg_scan_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en, wr_dp, en;
  logic [2:0] wr_idx;
  logic [3:0] wr_char;

  logic [3:0] an_a;  logic [6:0] seg_a; logic dp_a; logic [1:0] idx_a;
  logic [5:0] an_b;  logic [6:0] seg_b; logic dp_b; logic [2:0] idx_b;

  int checks = 0;
  int errors = 0;
  bit cmp_on = 1'b0;

  always #5 clk = ~clk;

  seg_scan_driver #(.NUM_DIGITS(4), .DWELL(4), .GUARD(1)) dut_a (
    .state_clk(clk), .reset(rst), .wr_en(wr_en), .wr_idx(wr_idx[1:0]),
    .wr_char(wr_char), .wr_dp(wr_dp), .en(en),
    .an(an_a), .seg(seg_a), .dp(dp_a), .digit_idx(idx_a)
  );

  seg_scan_driver #(.NUM_DIGITS(6), .DWELL(8), .GUARD(2)) dut_b (
    .state_clk(clk), .reset(rst), .wr_en(wr_en), .wr_idx(wr_idx),
    .wr_char(wr_char), .wr_dp(wr_dp), .en(en),
    .an(an_b), .seg(seg_b), .dp(dp_b), .digit_idx(idx_b)
  );

  // Reference glyphs, active-low {a..g}.
  logic [6:0] ref_tab [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b1111111
  };

  int pn [2] = '{4, 6};
  int pd [2] = '{4, 8};
  int pg [2] = '{1, 2};

  int         mk    [2];
  logic [3:0] mchar [2][8];
  logic       mdp   [2][8];
  logic       mlit  [2];
  logic [7:0] e_an  [2];
  logic [6:0] e_seg [2];
  logic       e_dp  [2];
  int         e_idx [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: edge k after release is phase (k-1)%DWELL of slot (k-1)/DWELL.
  task automatic model_step();
    int ph, d, widx;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        mk[i] = 0;
        for (int j = 0; j < 8; j++) begin
          mchar[i][j] = 4'hF;
          mdp[i][j]   = 1'b0;
        end
        mlit[i]  = 1'b0;
        e_an[i]  = 8'hFF;
        e_seg[i] = 7'h7F;
        e_dp[i]  = 1'b1;
        e_idx[i] = 0;
      end else begin
        mk[i]++;
        ph = (mk[i] - 1) % pd[i];
        d  = pn[i] - 1 - ((mk[i] - 1) / pd[i]) % pn[i];
        if (ph == 0) begin
          e_seg[i] = ref_tab[mchar[i][d]];
          e_dp[i]  = ~mdp[i][d];
          mlit[i]  = 1'b0;
        end else if (ph == pg[i]) begin
          mlit[i] = en;
        end else if (!en) begin
          mlit[i] = 1'b0;
        end
        e_an[i] = 8'hFF;
        if (mlit[i]) e_an[i][d] = 1'b0;
        e_idx[i] = d;
        widx = (i == 0) ? int'(wr_idx[1:0]) : int'(wr_idx);
        if (wr_en && widx < pn[i]) begin
          mchar[i][widx] = wr_char;
          mdp[i][widx]   = wr_dp;
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (cmp_on) begin
      check("an_a",  32'(an_a),  32'(e_an[0][3:0]));
      check("seg_a", 32'(seg_a), 32'(e_seg[0]));
      check("dp_a",  32'(dp_a),  32'(e_dp[0]));
      check("idx_a", 32'(idx_a), 32'(e_idx[0]));
      check("an_b",  32'(an_b),  32'(e_an[1][5:0]));
      check("seg_b", 32'(seg_b), 32'(e_seg[1]));
      check("dp_b",  32'(dp_b),  32'(e_dp[1]));
      check("idx_b", 32'(idx_b), 32'(e_idx[1]));
    end
  end

  task automatic wait_an(input logic [3:0] v, input string name);
    int n = 0;
    while (an_a !== v && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (an_a !== v) begin
      errors++;
      $display("FAIL %s: timeout, an_a=%b expected %b", name, an_a, v);
    end
  endtask

  task automatic write(input int idx, input logic [3:0] ch, input logic d);
    wr_en = 1'b1; wr_idx = 3'(idx); wr_char = ch; wr_dp = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1; wr_en = 1'b0; wr_idx = '0; wr_char = '0; wr_dp = 1'b0; en = 1'b1;
    repeat (2) @(negedge clk);
    cmp_on = 1'b1;
    check("rst_an",  32'(an_a),  32'hF);
    check("rst_seg", 32'(seg_a), 32'h7F);
    check("rst_dp",  32'(dp_a),  32'h1);
    check("rst_idx", 32'(idx_a), 32'h0);

    // Release: one off cycle on digit 3, then digit 3 lights.
    rst = 1'b0;
    @(negedge clk);
    check("first_idx", 32'(idx_a), 32'h3);
    check("first_an",  32'(an_a),  32'hF);
    check("first_idxb", 32'(idx_b), 32'h5);
    @(negedge clk);
    check("guard_an", 32'(an_a), 32'b0111);

    write(3, 4'h1, 1'b0);
    write(2, 4'h2, 1'b0);
    write(1, 4'h3, 1'b1);
    write(0, 4'h4, 1'b0);
    repeat (16) @(negedge clk);
    wait_an(4'b1011, "wait_1011");
    check("seg_two", 32'(seg_a), 32'b0010010);
    wait_an(4'b1101, "wait_1101");
    check("seg_three", 32'(seg_a), 32'b0000110);
    check("dp_three",  32'(dp_a),  32'h0);

    // Write digit 2 on the very edge of its snapshot.
    n = 0;
    while (mk[0] % 16 != 4 && n < 100) begin
      @(negedge clk);
      n++;
    end
    write(2, 4'h8, 1'b0);
    wait_an(4'b1011, "snap_old_wait");
    check("snap_old", 32'(seg_a), 32'b0010010);
    n = 0;
    while (an_a === 4'b1011 && n < 100) begin
      @(negedge clk);
      n++;
    end
    wait_an(4'b1011, "snap_new_wait");
    check("snap_new", 32'(seg_a), 32'b0000000);

    // Asynchronous reset mid-slot.
    wait_an(4'b1101, "pre_reset");
    #2 rst = 1'b1;
    #1;
    check("async_an",  32'(an_a),  32'hF);
    check("async_seg", 32'(seg_a), 32'h7F);
    check("async_dp",  32'(dp_a),  32'h1);
    check("async_anb", 32'(an_b),  32'h3F);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("restart_idx", 32'(idx_a), 32'h3);
    repeat (20) @(negedge clk);
    check("blank_seg", 32'(seg_a), 32'h7F);

    // Display disable mid-frame.
    write(3, 4'h5, 1'b1);
    write(0, 4'hC, 1'b0);
    repeat (5) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      check("en_off_an", 32'(an_a), 32'hF);
      @(negedge clk);
    end
    en = 1'b1;
    repeat (20) @(negedge clk);

    // Out-of-range index on the six-digit instance leaves its buffer blank.
    do_reset();
    write(7, 4'h0, 1'b1);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      check("oor_seg_b", 32'(seg_b), 32'h7F);
      check("oor_dp_b",  32'(dp_b),  32'h1);
    end

    // Randomized traffic checked by the model.
    for (int i = 0; i < 2500; i++) begin
      wr_en   = ($urandom_range(0, 3) == 0);
      wr_idx  = 3'($urandom_range(0, 7));
      wr_char = 4'($urandom_range(0, 15));
      wr_dp   = 1'($urandom_range(0, 1));
      en      = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 999) == 0) rst = 1'b1;
      else rst = 1'b0;
      @(negedge clk);
    end
    rst = 1'b0; wr_en = 1'b0; en = 1'b1;
    repeat (4) @(negedge clk);

    cmp_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog: simulation did not complete, expected finish before %0t", $time);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Parametrised multiplexed seven-segment scan driver: holds one 4-bit character code plus decimal-point bit per digit, time-multiplexes NUM_DIGITS common-anode digits from the divided state_clk tick, and inserts a configurable all-off guard window before each anode turns on. It sits between the UART receive path, which writes decoded characters into it, and the board's anode/segment pins. It is the N-digit, ghost-free successor of the fixed four-digit driver.

## Interface
- NUM_DIGITS, 4, digits scanned; ≥2.
- DWELL, 4, state_clk cycles per digit slot; ≥2.
- GUARD, 1, all-anodes-off cycles at the start of each slot; 1 ≤ GUARD < DWELL.
- IDX_W, $clog2(NUM_DIGITS), width of the digit index.

- state_clk  in  1  scan tick clock.
- reset  in  1  asynchronous, active-high.
- wr_en  in  1  write strobe for the character buffer.
- wr_idx  in  IDX_W  digit written; values ≥ NUM_DIGITS are ignored.
- wr_char  in  4  character code.
- wr_dp  in  1  decimal point for that digit, 1 = lit.
- en  in  1  display enable; 0 forces all anodes off.
- an  out  NUM_DIGITS  anode drives, active-low; an[NUM_DIGITS-1] is leftmost.
- seg  out  7  {a,b,c,d,e,f,g}, active-low.
- dp  out  1  decimal point, active-low.
- digit_idx  out  IDX_W  digit owning the current slot.

## Operation
- Character buffer: NUM_DIGITS entries of {char[3:0], dp}. Reset value: char 4'hF (blank), dp 0. Write occurs on the state_clk edge where wr_en=1 and wr_idx<NUM_DIGITS.
- Decode, active-low {a..g}:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
  - A=0001000, b=1100000, C=0110001, d=1000010, E=0110000
  - F=1111111 (blank)
- Scan state: digit_idx and phase (0..DWELL-1). Phase increments each edge. When phase wraps to 0, digit_idx decrements, wrapping 0 → NUM_DIGITS-1. Order is leftmost first.
- At the edge entering phase 0, the slot's entry is snapshotted: seg = decode(char), dp = ~dp_bit, an = all 1.
- At the edge entering phase GUARD: an[digit_idx] = 0 if en=1.
- Phases GUARD..DWELL-1 hold the anode on. seg/dp never change while any anode is low.
- en=0 drives an to all 1 on the next edge. Counters keep running. With en back at 1, the anode turns on only at the next phase-GUARD edge.

## Timing
- Reset values: an all 1, seg 7'h7F, dp 1, digit_idx 0, phase DWELL-1, buffer blank.
- First edge after reset release: digit_idx = NUM_DIGITS-1, phase 0, seg loaded, anodes off.
- Edge GUARD after release: an[NUM_DIGITS-1] goes low.
- Slot = DWELL cycles. Frame = NUM_DIGITS·DWELL cycles. Each digit is lit for DWELL-GUARD cycles per frame.
- Write latency: a written entry appears at that digit's next phase-0 snapshot.
- Write to the digit on the same edge as its phase-0 snapshot: the snapshot takes the old value; the new value shows one frame later.
- Write to the digit currently lit: the display is unchanged until the next frame.
- Reset mid-slot: all outputs and the buffer return to reset values immediately, asynchronously. No anode remains low.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- seg_pkg holds:
  - the code constants (CHAR_BLANK = 4'hF)
  - SEG_OFF = 7'h7F
  - the decode function or constant array shared with the existing decoder
- Sub-module seg_decoder: combinational 4-bit → 7-bit per the table above. It is instantiated once on the snapshot read path.
- Top module contains the buffer, scan counters, and output registers.

## Test plan
- Reset release, defaults (4/4/1): an=1111 for 1 cycle, then an cycles 0111, 1011, 1101, 1110 each 3 cycles separated by 1-cycle 1111. seg=7'h7F throughout (blank).
- Write 1,2,3,4 to idx 3,2,1,0 with dp on idx 1: during the an=1011 window seg=0010010. During an=1101, seg=0000110 and dp=0. No seg change while any anode is low.
- Write idx 2 = 8 on the edge its phase-0 snapshot occurs: the current frame shows the old code, the next frame shows 0000000.
- Assert reset while an=1101: an=1111, seg=7'h7F immediately. After release, the buffer is blank and the scan restarts at digit 3.
- en=0 for 10 cycles mid-frame: an stays 1111 and digit_idx keeps advancing. After en=1, the next anode goes low only at a phase-GUARD edge.
- NUM_DIGITS=6, DWELL=8, GUARD=2; wr_idx=7 ignored: frame of 48 cycles, digit order 5→0, each lit 6 cycles; buffer unchanged by the out-of-range write.
